id_stage_pipelined: RTL and testbench
=====================================

Name: id_stage_pipelined

Overview:
- Parametrised ARM decode stage. Contains the register file with write-through bypass, full NZCV condition evaluation, built-in hazard detection with a forwarding-aware mode, and the ID/EX pipeline register with stall and flush.
- Sits between the IF/ID register and the EXE stage.
- Outputs are registered: one-cycle latency from the instruction to the EXE-facing fields.

Parameters:
- DATA_W, 32, width of register values and PC.
- REG_ADDR_W, 4, register index width.
- REG_COUNT, 16, number of architectural registers (must be <= 2**REG_ADDR_W).
- FORWARD_EN, 0, 0 = stall on any RAW dependence on EXE/MEM; 1 = stall only on a load in EXE.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  branch taken; turn next ID/EX contents into a bubble
- instr_valid  in  1  IF/ID slot holds a real instruction
- instruction  in  32  ARM instruction word
- pc_in  in  DATA_W  PC of instruction
- status  in  4  NZCV flags {N,Z,C,V}
- wb_en_in  in  1  writeback enable
- wb_dest  in  REG_ADDR_W  writeback register
- wb_value  in  DATA_W  writeback data
- exe_wb_en, mem_wb_en  in  1  EXE/MEM stage will write a register
- exe_dest, mem_dest  in  REG_ADDR_W  EXE/MEM destination registers
- exe_mem_r_en  in  1  EXE stage holds a load
- hazard  out  1  combinational stall request to IF/PC
- out_valid  out  1  ID/EX slot holds an executing instruction
- wb_en, mem_r_en, mem_w_en, b, s  out  1  registered controls
- exe_cmd  out  4  registered ALU command
- dest, src1, src2  out  REG_ADDR_W  registered rd, rn, second source
- imm  out  1  registered I bit
- shift_operand  out  12  instruction[11:0]
- signed_imm_24  out  24  instruction[23:0]
- val_rn, val_rm  out  DATA_W  registered operand values
- pc_out  out  DATA_W  registered PC

Behaviour:
- Field decode: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], rn[19:16], rd[15:12], rm[3:0].
- mode 00, data processing (exe_cmd; wb_en=1 unless noted):
  - MOV 1101->0001; MVN 1111->1001; ADD 0100->0010; ADC 0101->0011; SUB 0010->0100; SBC 0110->0101; AND 0000->0110; ORR 1100->0111; EOR 0001->1000.
  - CMP 1010->0100 and TST 1000->0110, with wb_en=0.
  - s = S bit. Any other opcode decodes to NOP: all controls 0.
- mode 01, memory: exe_cmd 0010, s=0.
  - S=1 is LDR: mem_r_en=1, wb_en=1.
  - S=0 is STR: mem_w_en=1, wb_en=0.
- mode 10, branch: b=1, all other controls 0.
- mode 11: NOP.
- Second source: src2 = rd when STR, else rm.
- two_src = ~I | STR.
- uses_rn = 0 for MOV, MVN, branch and NOP; 1 otherwise.
- Condition codes:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL 1; 1111 evaluates to 0.
- Register file:
  - REG_COUNT x DATA_W, written on posedge when wb_en_in.
  - Read ports are combinational with write-through: if wb_en_in and wb_dest equals the read index, return wb_value.
  - wb_dest >= REG_COUNT is ignored on write and reads 0.
  - rst clears all registers to 0.
- Hazard, FORWARD_EN=0: hazard = instr_valid & ((uses_rn & match(rn)) | (two_src & match(src2))), where match(x) = (exe_wb_en & exe_dest==x) | (mem_wb_en & mem_dest==x).
- Hazard, FORWARD_EN=1: match(x) = exe_mem_r_en & exe_wb_en & exe_dest==x.
- hazard is forced 0 while flush=1.
- ID/EX register update at posedge, in priority order:
  1. rst: every output 0.
  2. flush: out_valid and all controls 0; data fields don't-care, hold.
  3. hazard, or !instr_valid: bubble, same as flush.
  4. Condition false: controls 0, out_valid 0, data fields loaded.
  5. Otherwise: load all fields, out_valid=1.
- Holding IF/ID on hazard is the caller's job; this block re-evaluates the same instruction each cycle until hazard clears.
- Simultaneous WB to the register being read: the new value is captured into val_rn/val_rm in that same edge.

Decomposition:
- Package arm_isa_pkg holds:
  - opcode, mode and cond localparams;
  - exe_cmd encodings;
  - a packed ctrl_t struct {wb_en, mem_r_en, mem_w_en, exe_cmd, b, s}.
- Sub-module: cond_check (cond[3:0], status[3:0] -> pass), purely combinational.
- The register file stays inline.

Test Plan:
- Reset, then ADD R1,R2,R3 (0xE0821003) with R2=5, R3=7 preloaded via WB -> next cycle out_valid=1, exe_cmd=0010, wb_en=1, val_rn=5, val_rm=7, dest=1.
- Write-through: same cycle wb_en_in=1, wb_dest=2, wb_value=0xAA, decode rn=2 -> val_rn=0xAA after that edge.
- Condition: ADDEQ with status Z=0 -> out_valid=0, wb_en=0; with Z=1 -> wb_en=1. GT with N=V=1, Z=0 -> pass.
- RAW, FORWARD_EN=0: exe_wb_en=1, exe_dest=3, instruction uses rm=3 -> hazard=1 and bubble; deassert exe_wb_en -> instruction issues.
- RAW, FORWARD_EN=1: same stimulus without exe_mem_r_en -> hazard=0; with exe_mem_r_en=1 -> hazard=1.
- STR R4,[R5] (0xE5854000) -> src2=4, two_src hazard checked on rd. flush asserted together with hazard -> hazard=0 and bubble. rst mid-stream -> all outputs 0 next edge.

Source files
------------

// File: rtl/arm_isa_pkg.sv
// ARM decode constants: instruction modes, data-processing opcodes,
// condition codes, ALU command encodings and the packed control bundle.
package arm_isa_pkg;

  // Instruction class, taken from instruction[27:26]
  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  // Data-processing opcodes, taken from instruction[24:21]
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  // Condition field values, taken from instruction[31:28]
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // ALU commands presented to EXE
  localparam logic [3:0] CMD_NOP = 4'b0000;
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic [3:0] exe_cmd;
    logic       b;
    logic       s;
  } ctrl_t;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluation against the current NZCV flags.
module cond_check
  import arm_isa_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);

  logic w_n, w_z, w_c, w_v;
  assign {w_n, w_z, w_c, w_v} = status;

  // Select the flag predicate named by the condition field; 1111 never passes
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = w_z;
      COND_NE: pass = ~w_z;
      COND_CS: pass = w_c;
      COND_CC: pass = ~w_c;
      COND_MI: pass = w_n;
      COND_PL: pass = ~w_n;
      COND_VS: pass = w_v;
      COND_VC: pass = ~w_v;
      COND_HI: pass = w_c & ~w_z;
      COND_LS: pass = ~w_c | w_z;
      COND_GE: pass = (w_n == w_v);
      COND_LT: pass = (w_n != w_v);
      COND_GT: pass = ~w_z & (w_n == w_v);
      COND_LE: pass = w_z | (w_n != w_v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_stage_pipelined.sv
// ARM decode stage: field decode, register file with write-through,
// condition check, RAW hazard detection and the ID/EX pipeline register.
module id_stage_pipelined
  import arm_isa_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int REG_COUNT  = 16,
  parameter int FORWARD_EN = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  instr_valid,
  input  logic [31:0]           instruction,
  input  logic [DATA_W-1:0]     pc_in,
  input  logic [3:0]            status,
  input  logic                  wb_en_in,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0]     wb_value,
  input  logic                  exe_wb_en,
  input  logic                  mem_wb_en,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  exe_mem_r_en,
  output logic                  hazard,
  output logic                  out_valid,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic                  b,
  output logic                  s,
  output logic [3:0]            exe_cmd,
  output logic [REG_ADDR_W-1:0] dest,
  output logic [REG_ADDR_W-1:0] src1,
  output logic [REG_ADDR_W-1:0] src2,
  output logic                  imm,
  output logic [11:0]           shift_operand,
  output logic [23:0]           signed_imm_24,
  output logic [DATA_W-1:0]     val_rn,
  output logic [DATA_W-1:0]     val_rm,
  output logic [DATA_W-1:0]     pc_out
);

  // Instruction fields
  logic [3:0]            w_cond;
  logic [1:0]            w_mode;
  logic                  w_i_bit;
  logic [3:0]            w_opcode;
  logic                  w_s_bit;
  logic [REG_ADDR_W-1:0] w_rn, w_rd, w_rm, w_src2;

  assign w_cond   = instruction[31:28];
  assign w_mode   = instruction[27:26];
  assign w_i_bit  = instruction[25];
  assign w_opcode = instruction[24:21];
  assign w_s_bit  = instruction[20];
  assign w_rn     = instruction[16 +: REG_ADDR_W];
  assign w_rd     = instruction[12 +: REG_ADDR_W];
  assign w_rm     = instruction[0  +: REG_ADDR_W];

  ctrl_t w_ctrl;
  logic  w_uses_rn, w_is_str, w_two_src, w_cond_pass, w_hazard, w_bubble;
  logic  w_dep_rn, w_dep_src2, w_wb_in_range;
  logic [DATA_W-1:0] w_val_rn, w_val_rm;

  logic [DATA_W-1:0] r_regs [REG_COUNT];
  logic              r_valid;
  ctrl_t             r_ctrl;
  logic [REG_ADDR_W-1:0] r_dest, r_src1, r_src2;
  logic              r_imm;
  logic [11:0]       r_shift;
  logic [23:0]       r_simm;
  logic [DATA_W-1:0] r_val_rn, r_val_rm, r_pc;

  assign w_src2        = w_is_str ? w_rd : w_rm;
  assign w_two_src     = ~w_i_bit | w_is_str;
  assign w_wb_in_range = (32'(wb_dest) < 32'(REG_COUNT));

  cond_check u_cond_check (
    .cond   (w_cond),
    .status (status),
    .pass   (w_cond_pass)
  );

  // Decode mode/opcode into the EXE control bundle and source usage
  always_comb begin
    w_ctrl    = '0;
    w_uses_rn = 1'b0;
    w_is_str  = 1'b0;
    case (w_mode)
      MODE_DP: begin
        w_uses_rn    = 1'b1;
        w_ctrl.wb_en = 1'b1;
        w_ctrl.s     = w_s_bit;
        case (w_opcode)
          OP_MOV: begin w_ctrl.exe_cmd = CMD_MOV; w_uses_rn = 1'b0; end
          OP_MVN: begin w_ctrl.exe_cmd = CMD_MVN; w_uses_rn = 1'b0; end
          OP_ADD: w_ctrl.exe_cmd = CMD_ADD;
          OP_ADC: w_ctrl.exe_cmd = CMD_ADC;
          OP_SUB: w_ctrl.exe_cmd = CMD_SUB;
          OP_SBC: w_ctrl.exe_cmd = CMD_SBC;
          OP_AND: w_ctrl.exe_cmd = CMD_AND;
          OP_ORR: w_ctrl.exe_cmd = CMD_ORR;
          OP_EOR: w_ctrl.exe_cmd = CMD_EOR;
          OP_CMP: begin w_ctrl.exe_cmd = CMD_SUB; w_ctrl.wb_en = 1'b0; end
          OP_TST: begin w_ctrl.exe_cmd = CMD_AND; w_ctrl.wb_en = 1'b0; end
          default: begin w_ctrl = '0; w_uses_rn = 1'b0; end
        endcase
      end
      MODE_MEM: begin
        w_uses_rn      = 1'b1;
        w_ctrl.exe_cmd = CMD_ADD;
        if (w_s_bit) begin
          w_ctrl.mem_r_en = 1'b1;
          w_ctrl.wb_en    = 1'b1;
        end else begin
          w_ctrl.mem_w_en = 1'b1;
          w_is_str        = 1'b1;
        end
      end
      MODE_BR: w_ctrl.b = 1'b1;
      default: w_ctrl = '0;
    endcase
  end

  // Register-file read ports with write-through of the same-cycle writeback
  always_comb begin
    w_val_rn = '0;
    w_val_rm = '0;
    for (int k = 0; k < REG_COUNT; k++) begin
      if (w_rn == REG_ADDR_W'(k)) begin
        w_val_rn = r_regs[k];
      end else begin
        w_val_rn = w_val_rn;
      end
      if (w_src2 == REG_ADDR_W'(k)) begin
        w_val_rm = r_regs[k];
      end else begin
        w_val_rm = w_val_rm;
      end
    end
    if (wb_en_in && w_wb_in_range && (wb_dest == w_rn)) begin
      w_val_rn = wb_value;
    end else begin
      w_val_rn = w_val_rn;
    end
    if (wb_en_in && w_wb_in_range && (wb_dest == w_src2)) begin
      w_val_rm = wb_value;
    end else begin
      w_val_rm = w_val_rm;
    end
  end

  // RAW dependence: with forwarding only a load in EXE can't be bypassed
  always_comb begin
    if (FORWARD_EN != 0) begin
      w_dep_rn   = exe_mem_r_en & exe_wb_en & (exe_dest == w_rn);
      w_dep_src2 = exe_mem_r_en & exe_wb_en & (exe_dest == w_src2);
    end else begin
      w_dep_rn   = (exe_wb_en & (exe_dest == w_rn))   | (mem_wb_en & (mem_dest == w_rn));
      w_dep_src2 = (exe_wb_en & (exe_dest == w_src2)) | (mem_wb_en & (mem_dest == w_src2));
    end
    w_hazard = ~flush & instr_valid &
               ((w_uses_rn & w_dep_rn) | (w_two_src & w_dep_src2));
  end

  assign hazard   = w_hazard;
  assign w_bubble = flush | w_hazard | ~instr_valid;

  // Register file storage; out-of-range writeback indices are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < REG_COUNT; k++) r_regs[k] <= '0;
    end else if (wb_en_in && w_wb_in_range) begin
      for (int k = 0; k < REG_COUNT; k++) begin
        if (wb_dest == REG_ADDR_W'(k)) r_regs[k] <= wb_value;
      end
    end
  end

  // ID/EX control half: bubble on flush/hazard/empty slot, squash on failed cond
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (w_bubble || !w_cond_pass) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid <= 1'b1;
      r_ctrl  <= w_ctrl;
    end
  end

  // ID/EX data half: held across bubbles, loaded even when the condition fails
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest   <= '0;
      r_src1   <= '0;
      r_src2   <= '0;
      r_imm    <= 1'b0;
      r_shift  <= '0;
      r_simm   <= '0;
      r_val_rn <= '0;
      r_val_rm <= '0;
      r_pc     <= '0;
    end else if (!w_bubble) begin
      r_dest   <= w_rd;
      r_src1   <= w_rn;
      r_src2   <= w_src2;
      r_imm    <= w_i_bit;
      r_shift  <= instruction[11:0];
      r_simm   <= instruction[23:0];
      r_val_rn <= w_val_rn;
      r_val_rm <= w_val_rm;
      r_pc     <= pc_in;
    end
  end

  assign out_valid     = r_valid;
  assign wb_en         = r_ctrl.wb_en;
  assign mem_r_en      = r_ctrl.mem_r_en;
  assign mem_w_en      = r_ctrl.mem_w_en;
  assign b             = r_ctrl.b;
  assign s             = r_ctrl.s;
  assign exe_cmd       = r_ctrl.exe_cmd;
  assign dest          = r_dest;
  assign src1          = r_src1;
  assign src2          = r_src2;
  assign imm           = r_imm;
  assign shift_operand = r_shift;
  assign signed_imm_24 = r_simm;
  assign val_rn        = r_val_rn;
  assign val_rm        = r_val_rm;
  assign pc_out        = r_pc;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: one instance per hazard mode, a directed
// vector table, hand-written corner sequences and a randomized phase checked
// against a behavioural model of the decode stage.
module tb_id_stage_pipelined;

  typedef struct packed {
    logic        valid, wb, mr, mw, b, s;
    logic [3:0]  cmd, dest, src1, src2;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] si;
    logic [31:0] vrn, vrm, pc;
  } out_t;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  status;
    logic        exe_wb;
    logic [3:0]  exe_d;
    logic        mem_wb;
    logic [3:0]  mem_d;
    logic        ld;
    logic        fl;
    logic        vld;
    logic        h0;
    logic        h1;
    logic        v0;
    logic [3:0]  cmd0;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, instr_valid, wb_en_in, exe_wb_en, mem_wb_en, exe_mem_r_en;
  logic [31:0] instruction, pc_in, wb_value;
  logic [3:0]  status, wb_dest, exe_dest, mem_dest;

  logic        f0_hazard, f0_valid, f0_wb, f0_mr, f0_mw, f0_b, f0_s, f0_imm;
  logic [3:0]  f0_cmd, f0_dest, f0_src1, f0_src2;
  logic [11:0] f0_sh;
  logic [23:0] f0_si;
  logic [31:0] f0_vrn, f0_vrm, f0_pc;
  logic        f1_hazard, f1_valid, f1_wb, f1_mr, f1_mw, f1_b, f1_s, f1_imm;
  logic [3:0]  f1_cmd, f1_dest, f1_src1, f1_src2;
  logic [11:0] f1_sh;
  logic [23:0] f1_si;
  logic [31:0] f1_vrn, f1_vrm, f1_pc;

  id_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(4), .REG_COUNT(16), .FORWARD_EN(0)) u_f0 (
    .clk(clk), .rst(rst), .flush(flush), .instr_valid(instr_valid),
    .instruction(instruction), .pc_in(pc_in), .status(status),
    .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_dest(exe_dest),
    .mem_dest(mem_dest), .exe_mem_r_en(exe_mem_r_en), .hazard(f0_hazard),
    .out_valid(f0_valid), .wb_en(f0_wb), .mem_r_en(f0_mr), .mem_w_en(f0_mw),
    .b(f0_b), .s(f0_s), .exe_cmd(f0_cmd), .dest(f0_dest), .src1(f0_src1),
    .src2(f0_src2), .imm(f0_imm), .shift_operand(f0_sh), .signed_imm_24(f0_si),
    .val_rn(f0_vrn), .val_rm(f0_vrm), .pc_out(f0_pc)
  );

  id_stage_pipelined #(.DATA_W(32), .REG_ADDR_W(4), .REG_COUNT(16), .FORWARD_EN(1)) u_f1 (
    .clk(clk), .rst(rst), .flush(flush), .instr_valid(instr_valid),
    .instruction(instruction), .pc_in(pc_in), .status(status),
    .wb_en_in(wb_en_in), .wb_dest(wb_dest), .wb_value(wb_value),
    .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en), .exe_dest(exe_dest),
    .mem_dest(mem_dest), .exe_mem_r_en(exe_mem_r_en), .hazard(f1_hazard),
    .out_valid(f1_valid), .wb_en(f1_wb), .mem_r_en(f1_mr), .mem_w_en(f1_mw),
    .b(f1_b), .s(f1_s), .exe_cmd(f1_cmd), .dest(f1_dest), .src1(f1_src1),
    .src2(f1_src2), .imm(f1_imm), .shift_operand(f1_sh), .signed_imm_24(f1_si),
    .val_rn(f1_vrn), .val_rm(f1_vrm), .pc_out(f1_pc)
  );

  out_t d0, d1;
  assign d0 = {f0_valid, f0_wb, f0_mr, f0_mw, f0_b, f0_s, f0_cmd, f0_dest, f0_src1,
               f0_src2, f0_imm, f0_sh, f0_si, f0_vrn, f0_vrm, f0_pc};
  assign d1 = {f1_valid, f1_wb, f1_mr, f1_mw, f1_b, f1_s, f1_cmd, f1_dest, f1_src1,
               f1_src2, f1_imm, f1_sh, f1_si, f1_vrn, f1_vrm, f1_pc};

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  logic [31:0] m_regs [16];
  out_t        m_out0, m_out1;
  logic [3:0]  dp_cmd [16];
  bit          dp_ok  [16];
  logic        haz0_seen, haz1_seen;
  vec_t        tab [11];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ARM conditions come in complementary pairs: even code = predicate, odd = its inverse
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] st);
    logic n, z, cf, v, r;
    {n, z, cf, v} = st;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    return c[0] ? ~r : r;
  endfunction

  function automatic logic [31:0] rd_reg(input logic [3:0] idx);
    if (wb_en_in && wb_dest == idx) return wb_value;
    return m_regs[idx];
  endfunction

  function automatic out_t model(input out_t cur, input bit fwd, output logic haz);
    out_t nx;
    logic [1:0] mode;
    logic       ib, sb, is_str, uses_rn;
    logic [3:0] op, rn, rd, rm, s2;
    logic [3:0] readers[$];
    logic [3:0] writers[$];
    nx = cur;
    mode = instruction[27:26]; ib = instruction[25]; op = instruction[24:21];
    sb = instruction[20]; rn = instruction[19:16]; rd = instruction[15:12]; rm = instruction[3:0];
    nx.wb = 0; nx.mr = 0; nx.mw = 0; nx.b = 0; nx.s = 0; nx.cmd = 4'h0;
    is_str = 0; uses_rn = 0;
    if (mode == 2'b00 && dp_ok[op]) begin
      nx.cmd = dp_cmd[op];
      nx.wb = !(op == 4'b1010 || op == 4'b1000);
      nx.s = sb;
      uses_rn = !(op == 4'b1101 || op == 4'b1111);
    end else if (mode == 2'b01) begin
      nx.cmd = 4'b0010; uses_rn = 1;
      if (sb) begin nx.mr = 1; nx.wb = 1; end
      else begin nx.mw = 1; is_str = 1; end
    end else if (mode == 2'b10) begin
      nx.b = 1;
    end
    s2 = is_str ? rd : rm;
    if (uses_rn) readers.push_back(rn);
    if (!ib || is_str) readers.push_back(s2);
    if (fwd) begin
      if (exe_mem_r_en && exe_wb_en) writers.push_back(exe_dest);
    end else begin
      if (exe_wb_en) writers.push_back(exe_dest);
      if (mem_wb_en) writers.push_back(mem_dest);
    end
    haz = 0;
    foreach (readers[i]) foreach (writers[j]) if (readers[i] == writers[j]) haz = 1;
    haz = haz & instr_valid & !flush;
    if (flush || haz || !instr_valid) begin
      nx = cur;
      nx.valid = 0; nx.wb = 0; nx.mr = 0; nx.mw = 0; nx.b = 0; nx.s = 0; nx.cmd = 4'h0;
      return nx;
    end
    nx.dest = rd; nx.src1 = rn; nx.src2 = s2; nx.imm = ib;
    nx.sh = instruction[11:0]; nx.si = instruction[23:0];
    nx.vrn = rd_reg(rn); nx.vrm = rd_reg(s2); nx.pc = pc_in;
    if (!cond_ok(instruction[31:28], status)) begin
      nx.valid = 0; nx.wb = 0; nx.mr = 0; nx.mw = 0; nx.b = 0; nx.s = 0; nx.cmd = 4'h0;
    end else begin
      nx.valid = 1;
    end
    return nx;
  endfunction

  // One clock: check combinational hazard, advance model, check registered outputs
  task automatic run_cycle();
    out_t n0, n1;
    logic e0, e1;
    #1;
    n0 = model(m_out0, 1'b0, e0);
    n1 = model(m_out1, 1'b1, e1);
    haz0_seen = f0_hazard;
    haz1_seen = f1_hazard;
    chk("hazard_fwd0", {159'b0, f0_hazard}, {159'b0, e0});
    chk("hazard_fwd1", {159'b0, f1_hazard}, {159'b0, e1});
    @(posedge clk);
    #1;
    if (rst) begin
      m_out0 = '0; m_out1 = '0;
      for (int k = 0; k < 16; k++) m_regs[k] = 32'h0;
    end else begin
      m_out0 = n0; m_out1 = n1;
      if (wb_en_in) m_regs[wb_dest] = wb_value;
    end
    chk("outputs_fwd0", {5'b0, d0}, {5'b0, m_out0});
    chk("outputs_fwd1", {5'b0, d1}, {5'b0, m_out1});
  endtask

  task automatic idle_inputs();
    flush = 0; instr_valid = 0; instruction = 32'h0; pc_in = 32'h100; status = 4'h0;
    wb_en_in = 0; wb_dest = 4'h0; wb_value = 32'h0;
    exe_wb_en = 0; mem_wb_en = 0; exe_dest = 4'h0; mem_dest = 4'h0; exe_mem_r_en = 0;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin dp_ok[k] = 0; dp_cmd[k] = 4'h0; m_regs[k] = 32'h0; end
    dp_ok[4'hD] = 1; dp_cmd[4'hD] = 4'h1;  // MOV
    dp_ok[4'hF] = 1; dp_cmd[4'hF] = 4'h9;  // MVN
    dp_ok[4'h4] = 1; dp_cmd[4'h4] = 4'h2;  // ADD
    dp_ok[4'h5] = 1; dp_cmd[4'h5] = 4'h3;  // ADC
    dp_ok[4'h2] = 1; dp_cmd[4'h2] = 4'h4;  // SUB
    dp_ok[4'h6] = 1; dp_cmd[4'h6] = 4'h5;  // SBC
    dp_ok[4'h0] = 1; dp_cmd[4'h0] = 4'h6;  // AND
    dp_ok[4'hC] = 1; dp_cmd[4'hC] = 4'h7;  // ORR
    dp_ok[4'h1] = 1; dp_cmd[4'h1] = 4'h8;  // EOR
    dp_ok[4'hA] = 1; dp_cmd[4'hA] = 4'h4;  // CMP
    dp_ok[4'h8] = 1; dp_cmd[4'h8] = 4'h6;  // TST
    m_out0 = '0; m_out1 = '0;

    //            instr         st     exwb exd   mwb md    ld fl vld  h0 h1 v0 cmd0
    tab[0]  = '{32'hE0821003, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 0, 1, 4'h2}; // ADD
    tab[1]  = '{32'h00821003, 4'h0, 0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 0, 0, 4'h0}; // ADDEQ Z=0
    tab[2]  = '{32'h00821003, 4'h4, 0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 0, 1, 4'h2}; // ADDEQ Z=1
    tab[3]  = '{32'hC0821003, 4'h9, 0, 4'h0, 0, 4'h0, 0, 0, 1,  0, 0, 1, 4'h2}; // ADDGT N=V=1
    tab[4]  = '{32'hE0821003, 4'h0, 1, 4'h3, 0, 4'h0, 0, 0, 1,  1, 0, 0, 4'h0}; // rm in EXE
    tab[5]  = '{32'hE0821003, 4'h0, 1, 4'h3, 0, 4'h0, 1, 0, 1,  1, 1, 0, 4'h0}; // load in EXE
    tab[6]  = '{32'hE0821003, 4'h0, 0, 4'h0, 1, 4'h2, 0, 0, 1,  1, 0, 0, 4'h0}; // rn in MEM
    tab[7]  = '{32'hE5854000, 4'h0, 1, 4'h4, 0, 4'h0, 0, 0, 1,  1, 0, 0, 4'h0}; // STR rd in EXE
    tab[8]  = '{32'hE5854000, 4'h0, 1, 4'h4, 0, 4'h0, 1, 1, 1,  0, 0, 0, 4'h0}; // flush wins
    tab[9]  = '{32'hE3A01005, 4'h0, 1, 4'h0, 0, 4'h0, 0, 0, 1,  0, 0, 1, 4'h1}; // MOV imm
    tab[10] = '{32'hE0821003, 4'h0, 1, 4'h3, 0, 4'h0, 0, 0, 0,  0, 0, 0, 4'h0}; // empty slot

    // Reset
    idle_inputs();
    rst = 1;
    run_cycle();
    run_cycle();
    chk("reset_state", {5'b0, d0}, 160'h0);
    rst = 0;

    // Preload R2=5, R3=7 through writeback
    wb_en_in = 1; wb_dest = 4'h2; wb_value = 32'h5;
    run_cycle();
    wb_dest = 4'h3; wb_value = 32'h7;
    run_cycle();
    wb_en_in = 0;

    // ADD R1,R2,R3
    instr_valid = 1; instruction = 32'hE0821003; status = 4'h0;
    run_cycle();
    chk("add_valid", {159'b0, f0_valid}, 160'h1);
    chk("add_cmd", {156'b0, f0_cmd}, 160'h2);
    chk("add_wb_en", {159'b0, f0_wb}, 160'h1);
    chk("add_val_rn", {128'b0, f0_vrn}, 160'h5);
    chk("add_val_rm", {128'b0, f0_vrm}, 160'h7);
    chk("add_dest", {156'b0, f0_dest}, 160'h1);

    // Directed table
    for (int i = 0; i < 11; i++) begin
      instruction = tab[i].instr; status = tab[i].status;
      exe_wb_en = tab[i].exe_wb; exe_dest = tab[i].exe_d;
      mem_wb_en = tab[i].mem_wb; mem_dest = tab[i].mem_d;
      exe_mem_r_en = tab[i].ld; flush = tab[i].fl; instr_valid = tab[i].vld;
      run_cycle();
      chk($sformatf("tab%0d_h0", i), {159'b0, haz0_seen}, {159'b0, tab[i].h0});
      chk($sformatf("tab%0d_h1", i), {159'b0, haz1_seen}, {159'b0, tab[i].h1});
      chk($sformatf("tab%0d_valid", i), {159'b0, f0_valid}, {159'b0, tab[i].v0});
      chk($sformatf("tab%0d_cmd", i), {156'b0, f0_cmd}, {156'b0, tab[i].cmd0});
    end
    idle_inputs();

    // Stall for two cycles on R3 in EXE, then issue once it clears
    instr_valid = 1; instruction = 32'hE0821003; exe_wb_en = 1; exe_dest = 4'h3;
    run_cycle();
    chk("stall1_valid", {159'b0, f0_valid}, 160'h0);
    run_cycle();
    chk("stall2_valid", {159'b0, f0_valid}, 160'h0);
    exe_wb_en = 0;
    run_cycle();
    chk("issue_valid", {159'b0, f0_valid}, 160'h1);

    // Write-through: R2 written while being read
    wb_en_in = 1; wb_dest = 4'h2; wb_value = 32'hAA;
    run_cycle();
    chk("wt_val_rn", {128'b0, f0_vrn}, 160'hAA);
    wb_en_in = 0;

    // Reset mid-stream
    rst = 1;
    run_cycle();
    chk("midrst_fwd0", {5'b0, d0}, 160'h0);
    chk("midrst_fwd1", {5'b0, d1}, 160'h0);
    rst = 0;

    // Randomized phase
    for (int n = 0; n < 400; n++) begin
      instruction = $urandom;
      if ($urandom_range(0, 1) == 0) instruction[31:28] = 4'hE;
      if ($urandom_range(0, 3) == 0) instruction[27:26] = 2'b01;
      pc_in = $urandom;
      status = 4'($urandom);
      instr_valid = ($urandom_range(0, 7) != 0);
      flush = ($urandom_range(0, 7) == 0);
      wb_en_in = $urandom_range(0, 1);
      wb_dest = 4'($urandom);
      if ($urandom_range(0, 2) == 0) wb_dest = instruction[19:16];
      wb_value = $urandom;
      exe_wb_en = $urandom_range(0, 1);
      exe_dest = ($urandom_range(0, 1) == 0) ? instruction[3:0] : 4'($urandom);
      mem_wb_en = $urandom_range(0, 1);
      mem_dest = ($urandom_range(0, 1) == 0) ? instruction[19:16] : instruction[15:12];
      exe_mem_r_en = $urandom_range(0, 1);
      run_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
